// File: rtl/char_seq_pkg.sv
// Shared types and constants for the character sequencer.
// CHAR_SEQ_BLANK_GAP_EN adds the GAP state used for the blank between loop passes.
package char_seq_pkg;

    localparam int unsigned CHAR_W = 7;
    localparam logic [CHAR_W-1:0] BLANK_CHAR = 7'h20;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        WAIT
`ifdef CHAR_SEQ_BLANK_GAP_EN
        ,
        GAP
`endif
    } state_t;

endpackage

// File: rtl/char_seq_if.sv
// Write handshake and character output bundle between the sequencer and its user.
interface char_seq_if;
    import char_seq_pkg::*;

    logic              wr_valid;
    logic [CHAR_W-1:0] wr_char;
    logic              wr_ready;
    logic              char_avail;
    logic [CHAR_W-1:0] char_out;

    modport master (
        output wr_valid, wr_char,
        input  wr_ready, char_avail, char_out
    );

    modport slave (
        input  wr_valid, wr_char,
        output wr_ready, char_avail, char_out
    );

endinterface

// File: rtl/char_seq_buffer.sv
// Append-only message store with length, full flag and a combinational read port.
module char_seq_buffer
    import char_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic                         clear,
    input  logic                         wr_valid,
    input  logic [CHAR_W-1:0]            wr_char,
    output logic                         wr_ready,
    input  logic [$clog2(DEPTH+1)-1:0]   rd_idx,
    output logic [CHAR_W-1:0]            rd_char,
    output logic [$clog2(DEPTH+1)-1:0]   len
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [CHAR_W-1:0] mem [DEPTH];
    logic              full;
    logic              we;

    assign full     = (len == CW'(DEPTH));
    assign wr_ready = ena & ~full;
    assign we       = wr_valid & wr_ready & ~clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len <= '0;
        end else if (ena) begin
            if (clear) begin
                len <= '0;
            end else if (we) begin
                len <= len + CW'(1);
            end
        end
    end

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[len[AW-1:0]] <= wr_char;
        end
    end

    assign rd_char = (rd_idx < CW'(DEPTH)) ? mem[rd_idx[AW-1:0]] : '0;

endmodule

// File: rtl/char_sequencer.sv
// Plays back a stored message as char_avail strobes paced by tick pulses.
// Define CHAR_SEQ_BLANK_GAP_EN to insert a blank character before each loop wrap.
module char_sequencer
    import char_seq_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned HOLD_TICKS = 30
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic                       tick,
    input  logic                       clear,
    input  logic                       start,
    input  logic                       loop,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count,
    char_seq_if.slave                  bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned HW = $clog2(HOLD_TICKS + 1);

    state_t            state, state_nxt;
    logic [CW-1:0]     rd_idx, rd_idx_nxt;
    logic [CW-1:0]     emit_idx;
    logic [HW-1:0]     hold_cnt, hold_nxt;
    logic [CHAR_W-1:0] char_q;
    logic [CHAR_W-1:0] rd_char;
    logic [CW-1:0]     len;
    logic              load_en;
    logic              load_blank;

    char_seq_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .clear    (clear),
        .wr_valid (bus.wr_valid),
        .wr_char  (bus.wr_char),
        .wr_ready (bus.wr_ready),
        .rd_idx   (emit_idx),
        .rd_char  (rd_char),
        .len      (len)
    );

    assign count = len;

    // The output character is captured on the edge entering EMIT/GAP so it
    // is valid in the same cycle as the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rd_idx   <= '0;
            hold_cnt <= '0;
            char_q   <= '0;
        end else if (ena) begin
            state    <= state_nxt;
            rd_idx   <= rd_idx_nxt;
            hold_cnt <= hold_nxt;
            if (load_en) begin
                char_q <= load_blank ? BLANK_CHAR : rd_char;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        rd_idx_nxt = rd_idx;
        hold_nxt   = hold_cnt;
        emit_idx   = rd_idx;
        load_en    = 1'b0;
        load_blank = 1'b0;
        if (clear) begin
            state_nxt  = IDLE;
            rd_idx_nxt = '0;
            hold_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (len != '0)) begin
                        state_nxt  = EMIT;
                        rd_idx_nxt = '0;
                        emit_idx   = '0;
                        load_en    = 1'b1;
                    end
                end
                EMIT: begin
                    rd_idx_nxt = rd_idx + CW'(1);
                    hold_nxt   = '0;
                    state_nxt  = WAIT;
                end
`ifdef CHAR_SEQ_BLANK_GAP_EN
                GAP: begin
                    rd_idx_nxt = '0;
                    hold_nxt   = '0;
                    state_nxt  = WAIT;
                end
`endif
                WAIT: begin
                    if (tick) begin
                        if (hold_cnt == HW'(HOLD_TICKS - 1)) begin
                            hold_nxt = '0;
                            // len is the pre-write value, so a same-cycle append waits a pass.
                            if (rd_idx < len) begin
                                state_nxt = EMIT;
                                load_en   = 1'b1;
                            end else if (loop) begin
`ifdef CHAR_SEQ_BLANK_GAP_EN
                                state_nxt  = GAP;
                                load_en    = 1'b1;
                                load_blank = 1'b1;
`else
                                state_nxt  = EMIT;
                                rd_idx_nxt = '0;
                                emit_idx   = '0;
                                load_en    = 1'b1;
`endif
                            end else begin
                                state_nxt = IDLE;
                            end
                        end else begin
                            hold_nxt = hold_cnt + HW'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.char_out   = char_q;
        busy           = (state != IDLE);
`ifdef CHAR_SEQ_BLANK_GAP_EN
        bus.char_avail = ena & ((state == EMIT) | (state == GAP));
`else
        bus.char_avail = ena & (state == EMIT);
`endif
    end

endmodule

// File: tb/tb_char_sequencer.sv
// Self-checking bench for char_sequencer: vector table, directed corner cases and
// randomized traffic against a queue-based message/playback model.
module tb_char_sequencer;

    localparam int DEPTH = 16;
    localparam int HOLD  = 30;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       tick = 1'b0;
    logic       clear = 1'b0;
    logic       start = 1'b0;
    logic       loop = 1'b0;
    logic       busy;
    logic [4:0] count;

    char_seq_if bus();

    char_sequencer #(.DEPTH(DEPTH), .HOLD_TICKS(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .tick  (tick),
        .clear (clear),
        .start (start),
        .loop  (loop),
        .busy  (busy),
        .count (count),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: stored message, playing flag, owed strobe, next index, ticks left.
    logic [6:0] q[$];
    bit         m_play, m_pend;
    int         m_pos, m_left;
    logic [6:0] m_char;

    logic [6:0] strobes[$];
    int         gaps[$];
    int         tick_since = 0;
    logic       prev_av = 1'b0;
    int         tcnt = 0;

    typedef struct {
        logic       wr;
        logic [6:0] ch;
        logic       clr;
        logic       st;
        logic       tk;
        logic       en;
        logic [4:0] e_count;
        logic       e_busy;
        logic       e_avail;
        logic [6:0] e_char;
        logic       e_ready;
    } vec_t;

    vec_t vecs[11];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_play = 0; m_pend = 0; m_pos = 0; m_left = 0; m_char = '0;
    endtask

    task automatic model_step();
        int sz;
        if (!ena) return;
        sz = q.size();
        if (clear) begin
            q.delete();
            m_play = 0; m_pend = 0; m_pos = 0;
            return;
        end
        if (!m_play) begin
            if (start && sz > 0) begin
                m_play = 1; m_pend = 1; m_char = q[0]; m_pos = 1;
            end
        end else if (m_pend) begin
            m_pend = 0; m_left = HOLD;
        end else if (tick) begin
            m_left--;
            if (m_left == 0) begin
                if (m_pos < sz) begin
                    m_char = q[m_pos]; m_pos++; m_pend = 1;
                end else if (loop) begin
`ifdef CHAR_SEQ_BLANK_GAP_EN
                    m_char = 7'h20; m_pos = 0;
`else
                    m_char = q[0]; m_pos = 1;
`endif
                    m_pend = 1;
                end else begin
                    m_play = 0;
                end
            end
        end
        if (bus.wr_valid && sz < DEPTH) q.push_back(bus.wr_char);
    endtask

    task automatic compare_all();
        check("char_avail", 32'(bus.char_avail), 32'(m_pend && ena));
        check("char_out", 32'(bus.char_out), 32'(m_char));
        check("busy", 32'(busy), 32'(m_play));
        check("count", 32'(count), 32'(q.size()));
        check("wr_ready", 32'(bus.wr_ready), 32'(ena && q.size() < DEPTH));
    endtask

    task automatic cycle();
        model_step();
        if (tick && ena && !prev_av) tick_since++;
        @(posedge clk);
        #1;
        compare_all();
        prev_av = bus.char_avail;
        if (bus.char_avail) begin
            strobes.push_back(bus.char_out);
            gaps.push_back(tick_since);
            tick_since = 0;
        end
    endtask

    task automatic run(int max, int want, bit until_idle);
        bit done = 0;
        for (int i = 0; i < max && !done; i++) begin
            tick = (tcnt % 3 == 0);
            tcnt++;
            cycle();
            if (want > 0 && strobes.size() >= want) done = 1;
            if (until_idle && !busy) done = 1;
        end
        tick = 1'b0;
        if (want > 0 || until_idle) check("run_timeout", 32'(done), 32'd1);
    endtask

    task automatic wr(logic [6:0] c);
        bus.wr_valid = 1'b1;
        bus.wr_char  = c;
        cycle();
        bus.wr_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic reset_seq();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev_av = 1'b0;
        tick_since = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] exp_loop[5];
        int n_before;

        bus.wr_valid = 1'b0;
        bus.wr_char  = '0;
        model_reset();

        // Reset values while rst_n is held low.
        #1;
        check("reset_avail", 32'(bus.char_avail), 32'd0);
        check("reset_char", 32'(bus.char_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_ready", 32'(bus.wr_ready), 32'd1);
        reset_seq();

        // wr, ch, clr, st, tk, en | count, busy, avail, char, ready
        vecs[0]  = '{1, 7'h41, 0, 0, 0, 1, 5'd1, 0, 0, 7'h00, 1};
        vecs[1]  = '{1, 7'h42, 0, 0, 0, 1, 5'd2, 0, 0, 7'h00, 1};
        vecs[2]  = '{1, 7'h43, 0, 0, 0, 1, 5'd3, 0, 0, 7'h00, 1};
        vecs[3]  = '{0, 7'h00, 0, 1, 0, 1, 5'd3, 1, 1, 7'h41, 1};
        vecs[4]  = '{0, 7'h00, 0, 0, 0, 1, 5'd3, 1, 0, 7'h41, 1};
        vecs[5]  = '{0, 7'h00, 0, 0, 1, 1, 5'd3, 1, 0, 7'h41, 1};
        vecs[6]  = '{1, 7'h44, 0, 0, 1, 0, 5'd3, 1, 0, 7'h41, 0};
        vecs[7]  = '{1, 7'h50, 1, 0, 0, 1, 5'd0, 0, 0, 7'h41, 1};
        vecs[8]  = '{0, 7'h00, 0, 1, 0, 1, 5'd0, 0, 0, 7'h41, 1};
        vecs[9]  = '{1, 7'h7f, 0, 0, 0, 1, 5'd1, 0, 0, 7'h41, 1};
        vecs[10] = '{0, 7'h00, 1, 1, 0, 1, 5'd0, 0, 0, 7'h41, 1};

        for (int i = 0; i < 11; i++) begin
            bus.wr_valid = vecs[i].wr;
            bus.wr_char  = vecs[i].ch;
            clear        = vecs[i].clr;
            start        = vecs[i].st;
            tick         = vecs[i].tk;
            ena          = vecs[i].en;
            model_step();
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("vec%0d_avail", i), 32'(bus.char_avail), 32'(vecs[i].e_avail));
            check($sformatf("vec%0d_char", i), 32'(bus.char_out), 32'(vecs[i].e_char));
            check($sformatf("vec%0d_ready", i), 32'(bus.wr_ready), 32'(vecs[i].e_ready));
        end
        bus.wr_valid = 1'b0; clear = 1'b0; start = 1'b0; tick = 1'b0; ena = 1'b1;

        // One-shot playback of "ABC".
        reset_seq();
        wr(7'h41); wr(7'h42); wr(7'h43);
        check("abc_count", 32'(count), 32'd3);
        strobes.delete(); gaps.delete();
        pulse_start();
        run(2000, 0, 1);
        check("oneshot_n", 32'(strobes.size()), 32'd3);
        if (strobes.size() == 3) begin
            check("oneshot_c0", 32'(strobes[0]), 32'h41);
            check("oneshot_c1", 32'(strobes[1]), 32'h42);
            check("oneshot_c2", 32'(strobes[2]), 32'h43);
            check("oneshot_gap1", 32'(gaps[1]), 32'(HOLD));
            check("oneshot_gap2", 32'(gaps[2]), 32'(HOLD));
        end
        check("oneshot_idle", 32'(busy), 32'd0);

        // Looping playback.
`ifdef CHAR_SEQ_BLANK_GAP_EN
        exp_loop = '{7'h41, 7'h42, 7'h43, 7'h20, 7'h41};
`else
        exp_loop = '{7'h41, 7'h42, 7'h43, 7'h41, 7'h42};
`endif
        loop = 1'b1;
        strobes.delete(); gaps.delete();
        pulse_start();
        run(3000, 5, 0);
        if (strobes.size() >= 5) begin
            for (int i = 0; i < 5; i++)
                check($sformatf("loop_c%0d", i), 32'(strobes[i]), 32'(exp_loop[i]));
        end
        pulse_clear();
        loop = 1'b0;

        // Fill past capacity.
        for (int i = 0; i < 17; i++) begin
            check($sformatf("fill_ready%0d", i), 32'(bus.wr_ready), 32'(i < DEPTH));
            wr(7'(i + 1));
        end
        check("fill_count", 32'(count), 32'(DEPTH));
        check("fill_ready_end", 32'(bus.wr_ready), 32'd0);
        pulse_clear();

        // clear together with a write during WAIT.
        wr(7'h41); wr(7'h42); wr(7'h43);
        strobes.delete(); gaps.delete();
        pulse_start();
        run(500, 1, 0);
        run(20, 0, 0);
        bus.wr_valid = 1'b1; bus.wr_char = 7'h55; clear = 1'b1;
        cycle();
        bus.wr_valid = 1'b0; clear = 1'b0;
        check("clrwr_count", 32'(count), 32'd0);
        check("clrwr_busy", 32'(busy), 32'd0);
        n_before = strobes.size();
        run(200, 0, 0);
        check("clrwr_nostrobe", 32'(strobes.size()), 32'(n_before));

        // Freeze with ena low mid-WAIT, ticks ignored.
        wr(7'h41); wr(7'h42); wr(7'h43);
        strobes.delete(); gaps.delete();
        pulse_start();
        run(500, 1, 0);
        run(30, 0, 0);
        n_before = strobes.size();
        ena = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick = (i % 33 == 5);
            cycle();
        end
        tick = 1'b0;
        ena = 1'b1;
        check("freeze_nostrobe", 32'(strobes.size()), 32'(n_before));
        run(500, 2, 0);
        if (gaps.size() >= 2) check("freeze_gap", 32'(gaps[1]), 32'(HOLD));
        pulse_clear();

        // start with an empty message.
        strobes.delete(); gaps.delete();
        pulse_start();
        check("empty_busy", 32'(busy), 32'd0);
        run(50, 0, 0);
        check("empty_nostrobe", 32'(strobes.size()), 32'd0);

        // Asynchronous reset mid-WAIT.
        wr(7'h41); wr(7'h42);
        pulse_start();
        run(500, 1, 0);
        run(10, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_avail", 32'(bus.char_avail), 32'd0);
        check("arst_char", 32'(bus.char_out), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_ready", 32'(bus.wr_ready), 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        prev_av = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            ena          = ($urandom_range(0, 15) != 0);
            bus.wr_valid = ($urandom_range(0, 5) == 0);
            bus.wr_char  = 7'($urandom);
            clear        = ($urandom_range(0, 149) == 0);
            start        = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 99) == 0) loop = ~loop;
            tick         = ($urandom_range(0, 2) == 0);
            cycle();
        end
        ena = 1'b1; bus.wr_valid = 1'b0; clear = 1'b0; start = 1'b0; tick = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
